// File: rtl/axil_slave_if.sv
// AXI4-Lite slave front end: independent AW/W capture, one outstanding write, 3-cycle read path.
// Optional address decoding with SLVERR responses is enabled by defining AXIL_SLVERR_EN.
module axil_slave_if #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  reg_wr_en,
  output logic [ADDR_WIDTH-1:0] reg_awaddr,
  output logic [31:0]           reg_wdata,
  output logic [3:0]            reg_wstrb,
  output logic                  reg_rd_en,
  output logic [ADDR_WIDTH-1:0] reg_araddr,
  input  logic [31:0]           reg_rdata
);

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_CAP, R_RESP} r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           rdata_q, rdata_d;

  logic aw_hs, w_hs, ar_hs, b_hs;
  logic aw_ok, ar_ok;

`ifdef AXIL_SLVERR_EN
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(0)) || (a == ADDR_WIDTH'(4)) || (a == ADDR_WIDTH'(8));
  endfunction
  assign aw_ok = addr_ok(awaddr_q);
  assign ar_ok = addr_ok(araddr_q);
`else
  assign aw_ok = 1'b1;
  assign ar_ok = 1'b1;
`endif

  // Readies are gated by rst_n so they read 0 throughout reset.
  assign s_awready = rst_n & ~aw_held_q & (w_state_q == W_IDLE);
  assign s_wready  = rst_n & ~w_held_q  & (w_state_q == W_IDLE);
  assign s_arready = rst_n & (r_state_q == R_IDLE);

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid  & s_wready;
  assign ar_hs = s_arvalid & s_arready;
  assign b_hs  = (w_state_q == W_RESP) & s_bready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_held_q && w_held_q) w_state_d = W_EXEC;
      W_EXEC:  w_state_d = W_RESP;
      W_RESP:  if (s_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_REQ;
      R_REQ:   r_state_d = R_CAP;
      R_CAP:   r_state_d = R_RESP;
      R_RESP:  if (s_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Holds load only on their own handshake; the B handshake releases both.
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_wdata;
      wstrb_d  = s_wstrb;
    end
    if (b_hs) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (ar_hs) araddr_d = s_araddr;
    if (r_state_q == R_CAP) rdata_d = ar_ok ? reg_rdata : 32'd0;
  end

  always_comb begin
    reg_wr_en = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = RESP_OKAY;
    reg_rd_en = 1'b0;
    s_rvalid  = 1'b0;
    s_rresp   = RESP_OKAY;
    case (w_state_q)
      W_EXEC: reg_wr_en = aw_ok;
      W_RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = aw_ok ? RESP_OKAY : RESP_SLVERR;
      end
      default: ;
    endcase
    case (r_state_q)
      R_REQ:  reg_rd_en = ar_ok;
      R_RESP: begin
        s_rvalid = 1'b1;
        s_rresp  = ar_ok ? RESP_OKAY : RESP_SLVERR;
      end
      default: ;
    endcase
  end

  assign reg_awaddr = awaddr_q;
  assign reg_wdata  = wdata_q;
  assign reg_wstrb  = wstrb_q;
  assign reg_araddr = araddr_q;
  assign s_rdata    = rdata_q;

endmodule
